// File: rtl/phase_wrap_multi_axis.sv
// Multi-channel phase accumulator with programmable 2*pi wrap and AXI-Stream handshake on both sides.
// Optional wrap-event counters and flags are built when PHASE_WRAP_WRAPCNT_EN is defined.
module phase_wrap_multi_axis #(
  parameter int NCH    = 2,
  parameter int LANE_W = 16,
  parameter int R      = 14,
  parameter int ACC_W  = R + 2,
  parameter int WCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*LANE_W-1:0]   S_AXIS_DATA_tdata,
  input  logic                    S_AXIS_DATA_tvalid,
  output logic                    S_AXIS_DATA_tready,
  output logic [NCH*LANE_W-1:0]   M_AXIS_WRAPPED_tdata,
  output logic                    M_AXIS_WRAPPED_tvalid,
  input  logic                    M_AXIS_WRAPPED_tready,
  input  logic [ACC_W-2:0]        cfg_s2pi,
  input  logic [ACC_W-2:0]        cfg_pad,
  input  logic [2*NCH-1:0]        cfg_mode,
  input  logic                    wrap_clr,
  output logic [NCH*WCNT_W-1:0]   wrap_count,
  output logic [NCH-1:0]          wrap_flag
);

  localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-R+1){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-R+1){1'b1}}, {(R-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
    else                  sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic signed [R-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX)      sat_out = OUT_MAX[R-1:0];
    else if (v < OUT_MIN) sat_out = OUT_MIN[R-1:0];
    else                  sat_out = v[R-1:0];
  endfunction

  logic                    accept;
  logic                    m_vld_q, m_vld_d;
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic signed [R-1:0]     lane_r [NCH];
  logic signed [ACC_W:0]   inc [NCH];
  logic signed [ACC_W:0]   sum [NCH];
  logic signed [R-1:0]     out_r [NCH];
  logic signed [LANE_W-1:0] out_ext [NCH];
  logic signed [ACC_W:0]   pad_x, s2pi_x;
  logic [NCH-1:0]          wrap_evt;
  logic [NCH*LANE_W-1:0]   tdata_c;

  assign S_AXIS_DATA_tready    = !rst && (!m_vld_q || M_AXIS_WRAPPED_tready);
  assign accept                = S_AXIS_DATA_tvalid && S_AXIS_DATA_tready;
  assign M_AXIS_WRAPPED_tvalid = m_vld_q;
  assign M_AXIS_WRAPPED_tdata  = tdata_c;
  assign pad_x                 = {2'b00, cfg_pad};
  assign s2pi_x                = {2'b00, cfg_s2pi};

  always_comb begin
    m_vld_d = m_vld_q;
    if (accept)                     m_vld_d = 1'b1;
    else if (M_AXIS_WRAPPED_tready) m_vld_d = 1'b0;
  end

  always_comb begin
    wrap_evt = '0;
    tdata_c  = '0;
    for (int i = 0; i < NCH; i++) begin
      lane_r[i] = S_AXIS_DATA_tdata[i*LANE_W +: R];
      inc[i]    = lane_r[i];
      sum[i]    = {acc_q[i][ACC_W-1], acc_q[i]} + inc[i];
      acc_d[i]  = acc_q[i];
      if (accept) begin
        unique case (cfg_mode[2*i +: 2])
          2'b00: begin
            // Sums exactly at +/-pad stay in place; only strict excursions wrap.
            if (sum[i] > pad_x) begin
              acc_d[i]    = sat_acc(sum[i] - s2pi_x);
              wrap_evt[i] = 1'b1;
            end else if (sum[i] < -pad_x) begin
              acc_d[i]    = sat_acc(sum[i] + s2pi_x);
              wrap_evt[i] = 1'b1;
            end else begin
              acc_d[i]    = sat_acc(sum[i]);
            end
          end
          2'b01:   acc_d[i] = lane_r[i];
          default: acc_d[i] = acc_q[i];
        endcase
      end
      out_r[i]   = sat_out(acc_q[i]);
      out_ext[i] = out_r[i];
      tdata_c[i*LANE_W +: LANE_W] = out_ext[i];
    end
  end

  // Output beat register: accumulators double as the held output data.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      for (int i = 0; i < NCH; i++) acc_q[i] <= acc_d[i];
    end
  end

  logic unused_in;
  assign unused_in = ^S_AXIS_DATA_tdata;

`ifdef PHASE_WRAP_WRAPCNT_EN
  logic [WCNT_W-1:0] wcnt_q [NCH];
  logic [WCNT_W-1:0] wcnt_d [NCH];
  logic [NCH-1:0]    wflag_q, wflag_d;

  always_comb begin
    wflag_d    = wrap_evt;
    wrap_count = '0;
    for (int i = 0; i < NCH; i++) begin
      wcnt_d[i] = wcnt_q[i];
      if (wrap_clr)                          wcnt_d[i] = '0;
      else if (wrap_evt[i] && ~&wcnt_q[i])   wcnt_d[i] = wcnt_q[i] + 1'b1;
      wrap_count[i*WCNT_W +: WCNT_W] = wcnt_q[i];
    end
  end

  // Wrap event stage: flag and count update on the same edge as the wrapping beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wflag_q <= '0;
      for (int i = 0; i < NCH; i++) wcnt_q[i] <= '0;
    end else begin
      wflag_q <= wflag_d;
      for (int i = 0; i < NCH; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end

  assign wrap_flag = wflag_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^{wrap_clr, wrap_evt};
  assign wrap_count  = '0;
  assign wrap_flag   = '0;
`endif

endmodule

// File: tb/tb_phase_wrap_multi_axis.sv
// Directed scoreboard bench for phase_wrap_multi_axis (NCH=2, R=14, WCNT_W=4).
module tb_phase_wrap_multi_axis;
  localparam int NCH = 2, LANE_W = 16, R = 14, ACC_W = 16, WCNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCH*LANE_W-1:0]  s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic [NCH*LANE_W-1:0]  m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [ACC_W-2:0]       cfg_s2pi;
  logic [ACC_W-2:0]       cfg_pad;
  logic [2*NCH-1:0]       cfg_mode;
  logic                   wrap_clr;
  logic [NCH*WCNT_W-1:0]  wrap_count;
  logic [NCH-1:0]         wrap_flag;

  int n_cmp = 0;
  int n_err = 0;
  int n_beat = 0;
  logic [31:0] exp_q[$];

  always #4 clk = ~clk;

  phase_wrap_multi_axis #(.NCH(NCH), .LANE_W(LANE_W), .R(R), .ACC_W(ACC_W), .WCNT_W(WCNT_W)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_DATA_tdata(s_tdata), .S_AXIS_DATA_tvalid(s_tvalid), .S_AXIS_DATA_tready(s_tready),
    .M_AXIS_WRAPPED_tdata(m_tdata), .M_AXIS_WRAPPED_tvalid(m_tvalid), .M_AXIS_WRAPPED_tready(m_tready),
    .cfg_s2pi(cfg_s2pi), .cfg_pad(cfg_pad), .cfg_mode(cfg_mode),
    .wrap_clr(wrap_clr), .wrap_count(wrap_count), .wrap_flag(wrap_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wrap(input string name, input logic [NCH-1:0] flag, input logic [NCH*WCNT_W-1:0] cnt);
`ifdef PHASE_WRAP_WRAPCNT_EN
    check({name, "_flag"}, 32'(wrap_flag), 32'(flag));
    check({name, "_count"}, 32'(wrap_count), 32'(cnt));
`else
    check({name, "_flag_off"}, 32'(wrap_flag), 32'd0);
    check({name, "_count_off"}, 32'(wrap_count), 32'd0);
`endif
  endtask

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic send(input int l0, input int l1, input logic [3:0] mode, input int e0, input int e1);
    bit ok = 0;
    bit rdy;
    s_tdata  = {16'(l1), 16'(l0)};
    cfg_mode = mode;
    s_tvalid = 1'b1;
    exp_q.push_back({16'(e1), 16'(e0)});
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    s_tvalid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: a beat transfers at the edge following a negedge with valid and ready high.
  initial begin
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        n_beat++;
        if (exp_q.size() == 0) begin
          check($sformatf("beat%0d_unexpected", n_beat), m_tdata, 32'hxxxxxxxx);
        end else begin
          check($sformatf("beat%0d", n_beat), m_tdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    cfg_s2pi = 15'd10000; cfg_pad = 15'd6000; cfg_mode = '0; wrap_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", m_tdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 32'(s_tready), 32'd1);
    check_wrap("post_rst", 2'b00, 8'h00);
    @(posedge clk); #1;

    // Ramp lane 0 by +1000 until it crosses +6000 and wraps to -3000.
    for (int k = 1; k <= 6; k++) send(1000, 0, 4'b0000, 1000 * k, 0);
    check_wrap("s1_at_pad", 2'b00, 8'h00);
    send(1000, 0, 4'b0000, -3000, 0);
    check_wrap("s1_wrap", 2'b01, 8'h01);

    // Lane 1 descends by -2500 and wraps from -7500 to +2500.
    send(0, -2500, 4'b0000, -3000, -2500);
    check("s2_signext", 32'(m_tdata[31:16]), 32'h0000F63C);
    check_wrap("s2_nowrap", 2'b00, 8'h01);
    send(0, -2500, 4'b0000, -3000, -5000);
    send(0, -2500, 4'b0000, -3000, 2500);
    check_wrap("s2_wrap", 2'b10, 8'h11);

    // Backpressure: repeat the lane 0 ramp while the sink stalls for 5 cycles.
    send(0, 0, 4'b0001, 0, 2500);
    fork
      begin
        for (int k = 1; k <= 6; k++) send(1000, 0, 4'b0000, 1000 * k, 2500);
        send(1000, 0, 4'b0000, -3000, 2500);
      end
      begin
        @(posedge clk); #1;
        m_tready = 1'b0;
        @(negedge clk);
        check("s3_stall_tready", 32'(s_tready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    check_wrap("s3_wrap", 2'b01, 8'h12);

    // Bypass, then integrate, then hold on lane 0 (lane 1 held at 2500).
    send(-123, 0, 4'b1001, -123, 2500);
    send(-123, 0, 4'b1001, -123, 2500);
    send(-123, 0, 4'b1000, -246, 2500);
    send(-123, 0, 4'b1000, -369, 2500);
    send(-123, 0, 4'b1010, -369, 2500);
    send(-123, 0, 4'b1010, -369, 2500);

    // Reset with a stalled beat in flight: the beat is dropped.
    send(4000, 0, 4'b1001, 4000, 2500);
    m_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("s5_rst_s_tready", 32'(s_tready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("s5_m_tvalid", 32'(m_tvalid), 32'd0);
    check("s5_m_tdata", m_tdata, 32'd0);
    check_wrap("s5_rst", 2'b00, 8'h00);
    m_tready = 1'b1;
    send(1000, 0, 4'b0000, 1000, 0);

    // Tight band forces a wrap on every beat; counter saturates at 15.
    cfg_pad = 15'd100; cfg_s2pi = 15'd200;
    for (int k = 0; k < 20; k++) send(200, 0, 4'b1000, 1000, 0);
    check_wrap("s6_sat", 2'b01, 8'h0F);
    wrap_clr = 1'b1;
    send(200, 0, 4'b1000, 1000, 0);
    wrap_clr = 1'b0;
    check_wrap("s6_clr", 2'b01, 8'h00);
    send(200, 0, 4'b1000, 1000, 0);
    check_wrap("s6_after_clr", 2'b01, 8'h01);

    // Wide band, no wrap: accumulator exceeds R bits and the output saturates.
    cfg_pad = 15'd20000; cfg_s2pi = 15'd0;
    send(8000, 0, 4'b1001, 8000, 0);
    send(8000, 0, 4'b1000, 8191, 0);
    check("s7_sat_hi", 32'(m_tdata[15:0]), 32'h00001FFF);
    send(-8192, 0, 4'b1001, -8192, 0);
    send(-8192, 0, 4'b1000, -8192, 0);
    check("s7_sat_lo", 32'(m_tdata[15:0]), 32'h0000E000);

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
